// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA transmit engine.
//   - default 640x480@60 raster timing (segments, totals, sync windows)
//   - rgb332_t pixel layout and the colour-bar test pattern helpers
package vga_pkg;

  localparam int unsigned PIX_DIV_DEF  = 2;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

  localparam int unsigned H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;          // 656
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;    // 751
  localparam int unsigned V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;          // 490
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;    // 491

  localparam bit SYNC_POL_DEF = 1'b0;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Bar k occupies bits [8k+7:8k].
  localparam int unsigned BAR_WIDTH = 80;
  localparam logic [63:0] BAR_TABLE = {8'hFF, 8'hFC, 8'hE3, 8'hE0,
                                       8'h1F, 8'h1C, 8'h03, 8'h00};

  function automatic logic [2:0] bar_index(input logic [9:0] x);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (x >= 10'(BAR_WIDTH * i)) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic rgb332_t bar_colour(input logic [2:0] k);
    return rgb332_t'(BAR_TABLE[{k, 3'b000} +: 8]);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel clock-enable divider plus horizontal/vertical raster
// counters and the combinational flags derived from them.
//   clk, rst     system clock, asynchronous active-high reset
//   en           raster enable; low holds divider and counters at 0
//   pix_ce       one clk in every PIX_DIV while enabled (first on the clk after en rises)
//   h_cnt        current column counter (0..H_TOTAL-1)
//   pix_y        current row counter, low 9 bits
//   active       current position inside the visible window
//   hsync_on     current column inside the horizontal sync pulse
//   vsync_on     current row inside the vertical sync pulse
//   frame_start  registered one-clk pulse on the (last,last) -> (0,0) wrap
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_ce,
  output logic [9:0] h_cnt,
  output logic [8:0] pix_y,
  output logic       active,
  output logic       hsync_on,
  output logic       vsync_on,
  output logic       frame_start
);

  localparam int unsigned DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC - 1;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC - 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             fs_q, fs_d;
  logic             h_wrap, v_wrap;

  always_comb begin
    pix_ce = en && (div_q == '0);
    h_wrap = (h_q == 10'(H_TOT - 1));
    v_wrap = (v_q == 10'(V_TOT - 1));
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    fs_d   = 1'b0;
    if (!en) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else begin
      div_d = (div_q == DIV_W'(PIX_DIV - 1)) ? '0 : div_q + 1'b1;
      if (pix_ce) begin
        h_d  = h_wrap ? '0 : h_q + 1'b1;
        if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
        fs_d = h_wrap && v_wrap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fs_q  <= fs_d;
    end
  end

  always_comb begin
    h_cnt       = h_q;
    pix_y       = v_q[8:0];
    active      = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    hsync_on    = (h_q >= 10'(HS_BEG)) && (h_q <= 10'(HS_END));
    vsync_on    = (v_q >= 10'(VS_BEG)) && (v_q <= 10'(VS_END));
    frame_start = fs_q;
  end

endmodule

// File: rtl/vga_tx.sv
// vga_tx: VGA transmit engine. Generates raster timing, requests one RGB332
// pixel per pixel tick from frame memory and drives the VGA pins.
//   CLK, RESET    system clock, asynchronous active-high reset
//   EN            raster enable
//   TP_SEL        colour-bar select (effective only with VGA_TX_TESTPAT_EN)
//   PIX_REQ       one-CLK read strobe; PIX_X / PIX_Y give the pixel address
//   PIX_DATA      memory data, valid exactly one CLK after PIX_REQ
//   HSYNC, VSYNC  sync pins, active level SYNC_POL
//   VGARED/GREEN/BLUE  colour pins, forced to 0 outside the visible window
//   FRAME_START   one-CLK pulse at each raster wrap to (0,0)
// Pins trail the pixel-request edge by a fixed 2 CLK for any PIX_DIV.
// Macro VGA_TX_TESTPAT_EN adds the 8-bar test pattern selected by TP_SEL.
module vga_tx
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = SYNC_POL_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       TP_SEL,
  output logic       PIX_REQ,
  output logic [9:0] PIX_X,
  output logic [8:0] PIX_Y,
  input  logic [7:0] PIX_DATA,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic [2:0] VGARED,
  output logic [2:0] VGAGREEN,
  output logic [1:0] VGABLUE,
  output logic       FRAME_START
);

  logic       pix_ce, active, hsync_on, vsync_on;
  logic [9:0] h_cnt;
  logic [8:0] pix_y;

  vga_timing_gen #(
    .PIX_DIV (PIX_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (CLK),
    .rst        (RESET),
    .en         (EN),
    .pix_ce     (pix_ce),
    .h_cnt      (h_cnt),
    .pix_y      (pix_y),
    .active     (active),
    .hsync_on   (hsync_on),
    .vsync_on   (vsync_on),
    .frame_start(FRAME_START)
  );

  // Stage 0: request/address plus blank and sync flags, loaded on pix_ce.
  logic       req0_q, req0_d, act0_q, act0_d, hs0_q, hs0_d, vs0_q, vs0_d;
  logic [9:0] x0_q, x0_d;
  logic [8:0] y0_q, y0_d;
  // Stage 1: the cycle in which memory presents PIX_DATA.
  logic       req1_q, req1_d, act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  // Stage 2: pin registers.
  logic       hs2_q, hs2_d, vs2_q, vs2_d;
  rgb332_t    rgb_q, rgb_d, src;

`ifdef VGA_TX_TESTPAT_EN
  logic [2:0] bar1_q, bar1_d;

  always_comb begin
    bar1_d = req0_q ? bar_index(x0_q) : bar1_q;
    src    = TP_SEL ? bar_colour(bar1_q) : rgb332_t'(PIX_DATA);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) bar1_q <= '0;
    else       bar1_q <= bar1_d;
  end
`else
  logic unused_tp_sel;
  assign unused_tp_sel = TP_SEL;

  always_comb src = rgb332_t'(PIX_DATA);
`endif

  always_comb begin
    req0_d = 1'b0;
    act0_d = act0_q;
    hs0_d  = hs0_q;
    vs0_d  = vs0_q;
    x0_d   = x0_q;
    y0_d   = y0_q;
    req1_d = req0_q;
    act1_d = act0_q;
    hs1_d  = hs0_q;
    vs1_d  = vs0_q;
    hs2_d  = hs1_q ? SYNC_POL : !SYNC_POL;
    vs2_d  = vs1_q ? SYNC_POL : !SYNC_POL;
    rgb_d  = rgb_q;
    // Colour holds between data cycles so it spans all PIX_DIV clocks of a pixel.
    if (!act1_q)     rgb_d = '0;
    else if (req1_q) rgb_d = src;
    if (pix_ce) begin
      req0_d = active;
      act0_d = active;
      hs0_d  = hsync_on;
      vs0_d  = vsync_on;
      x0_d   = h_cnt;
      y0_d   = pix_y;
    end
    // Disabled: flush the whole pipeline so pins go idle on the next edge.
    if (!EN) begin
      act0_d = 1'b0;
      hs0_d  = 1'b0;
      vs0_d  = 1'b0;
      x0_d   = '0;
      y0_d   = '0;
      req1_d = 1'b0;
      act1_d = 1'b0;
      hs1_d  = 1'b0;
      vs1_d  = 1'b0;
      hs2_d  = !SYNC_POL;
      vs2_d  = !SYNC_POL;
      rgb_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      req0_q <= 1'b0;
      act0_q <= 1'b0;
      hs0_q  <= 1'b0;
      vs0_q  <= 1'b0;
      x0_q   <= '0;
      y0_q   <= '0;
      req1_q <= 1'b0;
      act1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      hs2_q  <= !SYNC_POL;
      vs2_q  <= !SYNC_POL;
      rgb_q  <= '0;
    end else begin
      req0_q <= req0_d;
      act0_q <= act0_d;
      hs0_q  <= hs0_d;
      vs0_q  <= vs0_d;
      x0_q   <= x0_d;
      y0_q   <= y0_d;
      req1_q <= req1_d;
      act1_q <= act1_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      hs2_q  <= hs2_d;
      vs2_q  <= vs2_d;
      rgb_q  <= rgb_d;
    end
  end

  always_comb begin
    PIX_REQ  = req0_q;
    PIX_X    = x0_q;
    PIX_Y    = y0_q;
    HSYNC    = hs2_q;
    VSYNC    = vs2_q;
    VGARED   = rgb_q.r;
    VGAGREEN = rgb_q.g;
    VGABLUE  = rgb_q.b;
  end

endmodule
